y86_decode: RTL and testbench

- Decode stage of the sequential Y86-64 processor.
- Selects source registers srcA/srcB from icode/rA/rB, reads them from an internal 15-entry register file, and presents valA/valB to the execute stage.
- Sits between fetch (supplies icode, rA, rB) and execute/memory (consume valA, valB).

---
 rtl/y86_pkg.sv | 22 ++
 rtl/y86_regfile.sv | 46 ++++
 rtl/y86_decode.sv | 75 +++++++
 tb/tb_y86_decode.sv | 136 +++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icode and register-specifier constants
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'd0;
    localparam logic [3:0] I_NOP   = 4'd1;
    localparam logic [3:0] I_CMOV  = 4'd2;
    localparam logic [3:0] I_IRMOV = 4'd3;
    localparam logic [3:0] I_RMMOV = 4'd4;
    localparam logic [3:0] I_MRMOV = 4'd5;
    localparam logic [3:0] I_OP    = 4'd6;
    localparam logic [3:0] I_JXX   = 4'd7;
    localparam logic [3:0] I_CALL  = 4'd8;
    localparam logic [3:0] I_RET   = 4'd9;
    localparam logic [3:0] I_PUSH  = 4'd10;
    localparam logic [3:0] I_POP   = 4'd11;

    localparam logic [3:0] REG_RSP  = 4'd4;
    localparam logic [3:0] REG_NONE = 4'd15;

    localparam int NUM_REGS = 15;

endpackage

// File: rtl/y86_regfile.sv
// rtl/y86_regfile.sv - 15-entry register file, two async read ports; write ports under DECODE_WRITEBACK_EN
module y86_regfile
    import y86_pkg::*;
#(
    parameter int DATA_W            = 64,
    parameter int RESET_INIT_EN_VAL = 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef DECODE_WRITEBACK_EN
    input  logic [3:0]        dst_e,
    input  logic [DATA_W-1:0] val_e,
    input  logic [3:0]        dst_m,
    input  logic [DATA_W-1:0] val_m,
`endif
    input  logic [3:0]        raddr_a,
    input  logic [3:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [0:NUM_REGS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (RESET_INIT_EN_VAL != 0) ? DATA_W'(i) : '0;
            end
        end
`ifdef DECODE_WRITEBACK_EN
        else begin
            // M port is assigned last so it wins when both target the same register
            if (dst_e != REG_NONE) regs[dst_e] <= val_e;
            if (dst_m != REG_NONE) regs[dst_m] <= val_m;
        end
`endif
    end

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (raddr_a != REG_NONE) rdata_a = regs[raddr_a];
        if (raddr_b != REG_NONE) rdata_b = regs[raddr_b];
    end

endmodule

// File: rtl/y86_decode.sv
// rtl/y86_decode.sv - Y86-64 decode stage: source select and registered operand read (option: DECODE_WRITEBACK_EN)
module y86_decode
    import y86_pkg::*;
#(
    parameter int DATA_W            = 64,
    parameter int RESET_INIT_EN_VAL = 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef DECODE_WRITEBACK_EN
    input  logic [3:0]        dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valM,
`endif
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB
);

    logic [3:0]        src_a;
    logic [3:0]        src_b;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // Unlisted icodes fall to REG_NONE, so undefined encodings read as zero
    always_comb begin
        src_a = REG_NONE;
        case (icode)
            I_CMOV, I_RMMOV, I_OP, I_PUSH: src_a = rA;
            I_RET, I_POP:                  src_a = REG_RSP;
            default:                       src_a = REG_NONE;
        endcase
    end

    always_comb begin
        src_b = REG_NONE;
        case (icode)
            I_RMMOV, I_MRMOV, I_OP:        src_b = rB;
            I_CALL, I_RET, I_PUSH, I_POP:  src_b = REG_RSP;
            default:                       src_b = REG_NONE;
        endcase
    end

    y86_regfile #(
        .DATA_W            (DATA_W),
        .RESET_INIT_EN_VAL (RESET_INIT_EN_VAL)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
`ifdef DECODE_WRITEBACK_EN
        .dst_e   (dstE),
        .val_e   (valE),
        .dst_m   (dstM),
        .val_m   (valM),
`endif
        .raddr_a (src_a),
        .raddr_b (src_b),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            valA <= '0;
            valB <= '0;
        end else begin
            valA <= rd_a;
            valB <= rd_b;
        end
    end

endmodule

// File: tb/tb_y86_decode.sv
// tb/tb_y86_decode.sv - directed self-checking bench for y86_decode
module tb_y86_decode;

    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        icode;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;
`ifdef DECODE_WRITEBACK_EN
    logic [3:0]        dstE = 4'd15;
    logic [DATA_W-1:0] valE = '0;
    logic [3:0]        dstM = 4'd15;
    logic [DATA_W-1:0] valM = '0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    y86_decode #(
        .DATA_W            (DATA_W),
        .RESET_INIT_EN_VAL (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef DECODE_WRITEBACK_EN
        .dstE  (dstE),
        .valE  (valE),
        .dstM  (dstM),
        .valM  (valM),
`endif
        .icode (icode),
        .rA    (rA),
        .rB    (rB),
        .valA  (valA),
        .valB  (valB)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [DATA_W-1:0] exp_a, input logic [DATA_W-1:0] exp_b);
        @(negedge clk);
        icode = ic;
        rA    = ra;
        rB    = rb;
        @(posedge clk);
        #1;
        check({tag, "_valA"}, valA, exp_a);
        check({tag, "_valB"}, valB, exp_b);
    endtask

    initial begin
        rst   = 1'b1;
        icode = 4'd0;
        rA    = 4'd0;
        rB    = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valA", valA, 64'd0);
        check("reset_valB", valB, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        step("op_3_5",      4'd6,  4'd3,  4'd5,  64'd3,  64'd5);
        step("cmov_0_14",   4'd2,  4'd0,  4'd14, 64'd0,  64'd0);
        step("cmov_7",      4'd2,  4'd7,  4'd14, 64'd7,  64'd0);
        step("irmov",       4'd3,  4'd1,  4'd0,  64'd0,  64'd0);
        step("rmmov",       4'd4,  4'd3,  4'd4,  64'd3,  64'd4);
        step("mrmov",       4'd5,  4'd4,  4'd10, 64'd0,  64'd10);
        step("ret",         4'd9,  4'd2,  4'd3,  64'd4,  64'd4);
        step("push",        4'd10, 4'd9,  4'd1,  64'd9,  64'd4);
        step("pop",         4'd11, 4'd0,  4'd1,  64'd4,  64'd4);
        step("call",        4'd8,  4'd6,  4'd7,  64'd0,  64'd4);
        step("op_none",     4'd6,  4'd15, 4'd15, 64'd0,  64'd0);
        step("op_14_13",    4'd6,  4'd14, 4'd13, 64'd14, 64'd13);
        step("jxx",         4'd7,  4'd3,  4'd5,  64'd0,  64'd0);
        step("icode13",     4'd13, 4'd3,  4'd5,  64'd0,  64'd0);
        step("halt",        4'd0,  4'd3,  4'd5,  64'd0,  64'd0);
        step("nop",         4'd1,  4'd3,  4'd5,  64'd0,  64'd0);
        step("icode15",     4'd15, 4'd6,  4'd6,  64'd0,  64'd0);

        // Reset in the middle of operation overrides the decode that cycle
        @(negedge clk);
        rst   = 1'b1;
        icode = 4'd6;
        rA    = 4'd3;
        rB    = 4'd5;
        @(posedge clk);
        #1;
        check("midrst_valA", valA, 64'd0);
        check("midrst_valB", valB, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step("after_rst",   4'd6,  4'd12, 4'd11, 64'd12, 64'd11);

`ifdef DECODE_WRITEBACK_EN
        @(negedge clk);
        dstE = 4'd3;
        valE = 64'd100;
        icode = 4'd6;
        rA    = 4'd3;
        rB    = 4'd3;
        @(posedge clk);
        #1;
        check("wb_nobypass_valA", valA, 64'd3);
        @(negedge clk);
        dstE = 4'd5;
        valE = 64'd1;
        dstM = 4'd5;
        valM = 64'd2;
        @(posedge clk);
        #1;
        check("wb_e_valA", valA, 64'd100);
        @(negedge clk);
        dstE = 4'd15;
        dstM = 4'd15;
        step("wb_m_wins",   4'd6,  4'd3,  4'd5,  64'd100, 64'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
